// File: rtl/dds_sweep_controller.sv
// Frequency-word sweep controller for a DDS: steps KW between two limits in
// sawtooth or triangle fashion, holding each word for a programmable dwell.
module dds_sweep_controller #(
    parameter int KW_W    = 12,
    parameter int DWELL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start_In,
    input  logic               Stop_In,
    input  logic [KW_W-1:0]    Start_KW,
    input  logic [KW_W-1:0]    Stop_KW,
    input  logic [KW_W-1:0]    Step_KW,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Mode,
    input  logic [1:0]         Wave_Sel_In,
    input  logic               Wave_Auto,
    output logic [KW_W-1:0]    KW,
    output logic [2:0]         Wave_Sel,
    output logic               Busy,
    output logic               Sweep_Done,
    output logic               Cfg_Err
);

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [KW_W-1:0]    start_kw_s;
    logic [KW_W-1:0]    stop_kw_s;
    logic [KW_W-1:0]    step_kw_s;
    logic [DWELL_W-1:0] dwell_s;
    logic               mode_s;
    logic               auto_s;

    // min(kw + step, hi) evaluated one bit wider so the sum cannot wrap
    function automatic logic [KW_W-1:0] sat_add(input logic [KW_W-1:0] kw,
                                                input logic [KW_W-1:0] step,
                                                input logic [KW_W-1:0] hi);
        logic [KW_W:0] sum;
        sum = {1'b0, kw} + {1'b0, step};
        if (sum > {1'b0, hi})
            return hi;
        return sum[KW_W-1:0];
    endfunction

    // max(kw - step, lo) without ever forming a negative intermediate
    function automatic logic [KW_W-1:0] sat_sub(input logic [KW_W-1:0] kw,
                                                input logic [KW_W-1:0] step,
                                                input logic [KW_W-1:0] lo);
        logic [KW_W:0] floor_v;
        floor_v = {1'b0, lo} + {1'b0, step};
        if ({1'b0, kw} < floor_v)
            return lo;
        return kw - step;
    endfunction

    function automatic logic [2:0] wave_decode(input logic [1:0] sel);
        case (sel)
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // sin -> square -> sawtooth -> sin is a left rotate of the one-hot code
    function automatic logic [2:0] wave_rotate(input logic [2:0] w);
        return {w[1:0], w[2]};
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            KW         <= '0;
            Wave_Sel   <= 3'b001;
            Busy       <= 1'b0;
            Sweep_Done <= 1'b0;
            Cfg_Err    <= 1'b0;
            dwell_cnt  <= '0;
            start_kw_s <= '0;
            stop_kw_s  <= '0;
            step_kw_s  <= '0;
            dwell_s    <= '0;
            mode_s     <= 1'b0;
            auto_s     <= 1'b0;
        end else begin
            Sweep_Done <= 1'b0;
            Cfg_Err    <= 1'b0;
            if (Stop_In) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else if (Start_In && ((Start_KW >= Stop_KW) || (Step_KW == '0))) begin
                Cfg_Err <= 1'b1;
            end else if (Start_In) begin
                start_kw_s <= Start_KW;
                stop_kw_s  <= Stop_KW;
                step_kw_s  <= Step_KW;
                dwell_s    <= Dwell;
                mode_s     <= Mode;
                auto_s     <= Wave_Auto;
                KW         <= Start_KW;
                Wave_Sel   <= wave_decode(Wave_Sel_In);
                dwell_cnt  <= '0;
                state      <= RUN_UP;
                Busy       <= 1'b1;
            end else if (state != IDLE) begin
                if (dwell_cnt != dwell_s) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end else begin
                    dwell_cnt <= '0;
                    case (state)
                        RUN_UP: begin
                            if (KW != stop_kw_s) begin
                                KW <= sat_add(KW, step_kw_s, stop_kw_s);
                            end else if (!mode_s) begin
                                KW         <= start_kw_s;
                                Sweep_Done <= 1'b1;
                                if (auto_s)
                                    Wave_Sel <= wave_rotate(Wave_Sel);
                            end else begin
                                KW    <= sat_sub(stop_kw_s, step_kw_s, start_kw_s);
                                state <= RUN_DN;
                            end
                        end
                        RUN_DN: begin
                            if (KW != start_kw_s) begin
                                KW <= sat_sub(KW, step_kw_s, start_kw_s);
                            end else begin
                                KW         <= sat_add(start_kw_s, step_kw_s, stop_kw_s);
                                Sweep_Done <= 1'b1;
                                state      <= RUN_UP;
                                if (auto_s)
                                    Wave_Sel <= wave_rotate(Wave_Sel);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed sweeps pinned to literal sequences
// plus randomized control traffic checked every cycle against a sweep model.
module tb_dds_sweep_controller;

    localparam int KW_W    = 12;
    localparam int DWELL_W = 16;

    logic               CLK = 1'b0;
    logic               RST;
    logic               Start_In, Stop_In;
    logic [KW_W-1:0]    Start_KW, Stop_KW, Step_KW;
    logic [DWELL_W-1:0] Dwell;
    logic               Mode, Wave_Auto;
    logic [1:0]         Wave_Sel_In;
    logic [KW_W-1:0]    KW;
    logic [2:0]         Wave_Sel;
    logic               Busy, Sweep_Done, Cfg_Err;

    always #5 CLK = ~CLK;

    dds_sweep_controller #(.KW_W(KW_W), .DWELL_W(DWELL_W)) dut (
        .CLK(CLK), .RST(RST), .Start_In(Start_In), .Stop_In(Stop_In),
        .Start_KW(Start_KW), .Stop_KW(Stop_KW), .Step_KW(Step_KW),
        .Dwell(Dwell), .Mode(Mode), .Wave_Sel_In(Wave_Sel_In),
        .Wave_Auto(Wave_Auto), .KW(KW), .Wave_Sel(Wave_Sel), .Busy(Busy),
        .Sweep_Done(Sweep_Done), .Cfg_Err(Cfg_Err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sweep model: running flag, direction, current word, wave index 0..2
    int m_run, m_down, m_kw, m_wave, m_held, m_done, m_err;
    int s_start, s_stop, s_step, s_dwell, s_mode, s_auto;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_down = 0; m_kw = 0; m_wave = 0; m_held = 0;
        m_done = 0; m_err = 0;
        s_start = 0; s_stop = 0; s_step = 0; s_dwell = 0; s_mode = 0; s_auto = 0;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (RST) begin
            model_reset();
        end else if (Stop_In) begin
            m_run = 0;
        end else if (Start_In) begin
            if (int'(Start_KW) >= int'(Stop_KW) || Step_KW == 0) begin
                m_err = 1;
            end else begin
                s_start = Start_KW; s_stop = Stop_KW; s_step = Step_KW;
                s_dwell = Dwell; s_mode = Mode; s_auto = Wave_Auto;
                m_kw = s_start; m_held = 0; m_run = 1; m_down = 0;
                m_wave = (Wave_Sel_In == 2'd1) ? 1 : (Wave_Sel_In == 2'd2) ? 2 : 0;
            end
        end else if (m_run) begin
            m_held++;
            if (m_held == s_dwell + 1) begin
                m_held = 0;
                if (!m_down) begin
                    if (m_kw != s_stop) m_kw = imin(m_kw + s_step, s_stop);
                    else if (s_mode == 0) begin m_kw = s_start; m_done = 1; end
                    else begin m_kw = imax(s_stop - s_step, s_start); m_down = 1; end
                end else begin
                    if (m_kw != s_start) m_kw = imax(m_kw - s_step, s_start);
                    else begin m_kw = imin(s_start + s_step, s_stop); m_done = 1; m_down = 0; end
                end
                if (m_done && s_auto) m_wave = (m_wave + 1) % 3;
            end
        end
    endtask

    task automatic compare();
        chk("KW", KW, m_kw);
        chk("Wave_Sel", Wave_Sel, 1 << m_wave);
        chk("Busy", Busy, m_run);
        chk("Sweep_Done", Sweep_Done, m_done);
        chk("Cfg_Err", Cfg_Err, m_err);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare();
        Start_In = 1'b0;
        Stop_In  = 1'b0;
    endtask

    task automatic start(input int a, input int b, input int st, input int dw,
                         input int md, input int ws, input int au);
        Start_KW = a[KW_W-1:0]; Stop_KW = b[KW_W-1:0]; Step_KW = st[KW_W-1:0];
        Dwell = dw[DWELL_W-1:0]; Mode = md[0]; Wave_Sel_In = ws[1:0];
        Wave_Auto = au[0]; Start_In = 1'b1;
        cycle();
    endtask

    int saw_exp[9] = '{100, 100, 110, 110, 120, 120, 130, 130, 100};
    int tri_exp[9] = '{0, 10, 20, 25, 15, 5, 0, 10, 20};
    int wave_exp[3] = '{4, 1, 2};
    int wave_got[3];
    int n_done;

    initial begin
        RST = 1'b1; Start_In = 0; Stop_In = 0; Start_KW = 0; Stop_KW = 0;
        Step_KW = 0; Dwell = 0; Mode = 0; Wave_Sel_In = 0; Wave_Auto = 0;
        model_reset();
        #12;
        chk("reset_KW", KW, 0);
        chk("reset_Wave_Sel", Wave_Sel, 1);
        chk("reset_Busy", Busy, 0);
        compare();
        RST = 1'b0;
        cycle();

        // Sawtooth with a mid-run change of Start_KW that must be ignored
        start(100, 130, 10, 1, 0, 0, 0);
        chk("saw_kw_0", KW, saw_exp[0]);
        chk("saw_busy", Busy, 1);
        for (int i = 1; i < 9; i++) begin
            if (i == 2) Start_KW = 12'd5;
            cycle();
            chk($sformatf("saw_kw_%0d", i), KW, saw_exp[i]);
            chk($sformatf("saw_done_%0d", i), Sweep_Done, (i == 8) ? 1 : 0);
        end

        // Stop mid-dwell freezes KW
        Stop_In = 1'b1;
        cycle();
        chk("stop_busy", Busy, 0);
        chk("stop_kw", KW, 100);
        for (int i = 0; i < 3; i++) cycle();
        chk("idle_kw_hold", KW, 100);

        // Triangle with saturation at both limits
        start(0, 25, 10, 0, 1, 0, 0);
        chk("tri_kw_0", KW, tri_exp[0]);
        for (int i = 1; i < 9; i++) begin
            cycle();
            chk($sformatf("tri_kw_%0d", i), KW, tri_exp[i]);
            chk($sformatf("tri_done_%0d", i), Sweep_Done, (i == 7) ? 1 : 0);
        end
        Stop_In = 1'b1;
        cycle();
        chk("tri_stop_kw", KW, 20);

        // Rejected starts
        start(200, 200, 5, 0, 0, 0, 0);
        chk("rej_eq_err", Cfg_Err, 1);
        chk("rej_eq_busy", Busy, 0);
        chk("rej_eq_kw", KW, 20);
        cycle();
        chk("rej_err_pulse", Cfg_Err, 0);
        start(10, 50, 0, 0, 0, 0, 0);
        chk("rej_step_err", Cfg_Err, 1);
        chk("rej_step_kw", KW, 20);

        // Start and Stop together: stop wins
        Stop_In = 1'b1;
        start(10, 50, 5, 0, 0, 0, 0);
        chk("race_busy", Busy, 0);
        chk("race_kw", KW, 20);

        // Waveform rotation over three sawtooth sweeps
        start(0, 10, 10, 0, 0, 1, 1);
        chk("wave_init", Wave_Sel, 2);
        n_done = 0;
        for (int i = 0; i < 20 && n_done < 3; i++) begin
            cycle();
            if (Sweep_Done) begin
                wave_got[n_done] = Wave_Sel;
                n_done++;
            end
        end
        chk("wave_done_count", n_done, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("wave_rot_%0d", i), wave_got[i], wave_exp[i]);
        Stop_In = 1'b1;
        cycle();

        // Asynchronous reset mid-sweep at KW=120
        start(100, 130, 10, 1, 0, 2, 0);
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_rst_kw", KW, 120);
        #2 RST = 1'b1;
        #1;
        chk("arst_kw", KW, 0);
        chk("arst_wave", Wave_Sel, 1);
        chk("arst_busy", Busy, 0);
        chk("arst_done", Sweep_Done, 0);
        model_reset();
        cycle();
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("post_rst_idle", Busy, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            Start_KW = 12'($urandom_range(0, 200));
            Stop_KW  = 12'($urandom_range(0, 255));
            Step_KW  = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 70));
            Dwell    = 16'($urandom_range(0, 3));
            Mode     = 1'($urandom_range(0, 1));
            Wave_Sel_In = 2'($urandom_range(0, 3));
            Wave_Auto = 1'($urandom_range(0, 1));
            Start_In = ($urandom_range(0, 19) == 0);
            Stop_In  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b1;
                #1;
                model_reset();
                compare();
                #1 RST = 1'b0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_controller.md
DDS_SWEEP_CONTROLLER -- requirements
Module: dds_sweep_controller

Interface
REQ-001 The block SHALL have a single clock domain; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: KW_W, 12, frequency-word width.
REQ-003 Parameter: DWELL_W, 16, dwell-counter width.
REQ-004 CLK  input  1  system clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 Start_In  input  1  single-cycle start/restart request.
REQ-007 Stop_In  input  1  single-cycle stop request.
REQ-008 Start_KW  input  KW_W  sweep lower frequency word.
REQ-009 Stop_KW  input  KW_W  sweep upper frequency word.
REQ-010 Step_KW  input  KW_W  increment per step.
REQ-011 Dwell  input  DWELL_W  hold time per step, in cycles minus one.
REQ-012 Mode  input  1  0 = sawtooth sweep (up, wrap to start); 1 = triangle sweep (up/down).
REQ-013 Wave_Sel_In  input  2  initial waveform: 00 sin, 01 square, 10 sawtooth, 11 treated as sin.
REQ-014 Wave_Auto  input  1  1 = rotate waveform at each completed sweep.
REQ-015 KW  output  KW_W  frequency word to the DDS phase accumulator.
REQ-016 Wave_Sel  output  3  one-hot waveform select {sawtooth, square, sin}.
REQ-017 Busy  output  1  high while in RUN_UP or RUN_DN.
REQ-018 Sweep_Done  output  1  one-cycle pulse at end of each sweep.
REQ-019 Cfg_Err  output  1  one-cycle pulse when a Start is rejected.

Function
REQ-020 FSM states SHALL be IDLE, RUN_UP, RUN_DN; all outputs registered.
REQ-021 On Start_In, the block SHALL latch Start_KW, Stop_KW, Step_KW, Dwell, Mode, Wave_Auto into shadow registers; input changes during a run SHALL be ignored.
REQ-022 Start SHALL be rejected (state unchanged, Cfg_Err pulse next cycle) if Start_KW >= Stop_KW or Step_KW == 0.
REQ-023 Accepted Start SHALL, at that edge, load KW = Start_KW, Wave_Sel from Wave_Sel_In, clear the dwell counter, enter RUN_UP; Busy = 1 after the same edge.
REQ-024 Start while running SHALL restart identically to REQ-023.
REQ-025 Each KW value SHALL be held exactly Dwell+1 cycles; Dwell = 0 steps every cycle.
REQ-026 RUN_UP at dwell expiry, KW != Stop: KW <= min(KW + Step, Stop), computed at KW_W+1 bits (no wrap).
REQ-027 RUN_UP at dwell expiry, KW == Stop, Mode 0: KW <= Start, Sweep_Done pulse, remain RUN_UP.
REQ-028 RUN_UP at dwell expiry, KW == Stop, Mode 1: KW <= max(Stop - Step, Start), enter RUN_DN; no Sweep_Done.
REQ-029 RUN_DN at dwell expiry, KW != Start: KW <= max(KW - Step, Start), no underflow.
REQ-030 RUN_DN at dwell expiry, KW == Start: KW <= min(Start + Step, Stop), Sweep_Done pulse, enter RUN_UP.
REQ-031 With shadow Wave_Auto = 1, each Sweep_Done SHALL rotate Wave_Sel sin -> square -> sawtooth -> sin in the same edge.
REQ-032 Stop_In SHALL enter IDLE at the next edge, Busy = 0, KW and Wave_Sel frozen at last value.
REQ-033 Start_In and Stop_In in the same cycle: Stop SHALL win.
REQ-034 In IDLE, KW, Wave_Sel SHALL hold; Sweep_Done SHALL stay 0.

Reset
REQ-035 RST high SHALL immediately force IDLE, KW = 0, Wave_Sel = 3'b001, Busy = 0, Sweep_Done = 0, Cfg_Err = 0, dwell counter = 0, shadows = 0.
REQ-036 RST asserted mid-sweep SHALL abort without a Sweep_Done pulse; after release, the block SHALL wait in IDLE for Start_In.

Verification
REQ-037 Sawtooth: Start=100, Stop=130, Step=10, Dwell=1, Mode 0 -> KW 100,100,110,110,120,120,130,130,100...; Sweep_Done on the edge KW returns to 100.
REQ-038 Saturation/triangle: Start=0, Stop=25, Step=10, Dwell=0, Mode 1 -> KW 0,10,20,25,15,5,0,10...; Sweep_Done on the 0->10 edge only.
REQ-039 Rejection: Start=200, Stop=200 or Step=0 -> Cfg_Err one pulse, Busy stays 0, KW unchanged.
REQ-040 Wave rotation: Wave_Sel_In=01, Wave_Auto=1, three sweeps -> Wave_Sel 010,100,001,010.
REQ-041 Control races: Start+Stop same cycle -> IDLE; Stop mid-dwell -> Busy 0 next cycle, KW frozen; Start_KW changed mid-run -> no effect.
REQ-042 RST pulse mid-sweep at KW=120 -> KW=0, Wave_Sel=001, Busy=0 asynchronously; no Sweep_Done.
